// File: rtl/nios_mul_seq_ctrl_if.sv
// Bundles the CPU custom-instruction handshake and the shared 16x16 multiply-cell port.
// The sequencer connects through the slave view; the CPU and the cell are on the master side.
interface nios_mul_seq_ctrl_if;
    logic        start;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sign1;
    logic        sign2;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [15:0] mul_dataa;
    logic [15:0] mul_datab;
    logic        mul_ena;
    logic [31:0] mul_result;

    modport master (
        output start, src1, src2, sign1, sign2, mul_result,
        input  busy, done, result_lo, result_hi, mul_dataa, mul_datab, mul_ena
    );

    modport slave (
        input  start, src1, src2, sign1, sign2, mul_result,
        output busy, done, result_lo, result_hi, mul_dataa, mul_datab, mul_ena
    );
endinterface

// File: rtl/nios_mul_seq_ctrl.sv
// 32x32->64 multiply built from four passes through a pipelined unsigned 16x16 cell,
// with tagged accumulation of returning partial products and a final signed correction.
module nios_mul_seq_ctrl #(
    parameter int MUL_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_mul_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FIX, DONE} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  k_reg;
    logic [31:0] a_reg, b_reg;
    logic        sign1_reg, sign2_reg;
    logic [63:0] acc_reg;
    logic [63:0] result_reg;
    // Each tag is {valid, k}; the oldest stage lines up with the cell's mul_result.
    logic [MUL_LATENCY-1:0][2:0] tag_reg;

    logic        accept;
    logic        issue;
    logic        tag_valid;
    logic [1:0]  tag_k;
    logic        last_retire;
    logic [5:0]  shift;
    logic [63:0] corr_a, corr_b;
    logic [63:0] fix_value;

    assign accept      = (state_reg == IDLE) && bus.start;
    assign issue       = (state_reg == ISSUE);
    assign tag_valid   = tag_reg[MUL_LATENCY-1][2];
    assign tag_k       = tag_reg[MUL_LATENCY-1][1:0];
    assign last_retire = tag_valid && (tag_k == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = ISSUE;
            ISSUE:   if (k_reg == 2'd3) state_next = DRAIN;
            DRAIN:   if (last_retire) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shift = 6'd0;
        case (tag_k)
            2'd0:    shift = 6'd0;
            2'd1:    shift = 6'd16;
            2'd2:    shift = 6'd16;
            default: shift = 6'd32;
        endcase
    end

    // Signed operands are multiplied as unsigned; subtract the 2^32-weighted cross terms.
    always_comb begin
        corr_a    = (sign1_reg && a_reg[31]) ? {b_reg, 32'd0} : 64'd0;
        corr_b    = (sign2_reg && b_reg[31]) ? {a_reg, 32'd0} : 64'd0;
        fix_value = acc_reg - corr_a - corr_b;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k_reg      <= 2'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            sign1_reg  <= 1'b0;
            sign2_reg  <= 1'b0;
            acc_reg    <= 64'd0;
            result_reg <= 64'd0;
            tag_reg    <= '0;
        end else begin
            if (accept) begin
                a_reg     <= bus.src1;
                b_reg     <= bus.src2;
                sign1_reg <= bus.sign1;
                sign2_reg <= bus.sign2;
                acc_reg   <= 64'd0;
                k_reg     <= 2'd0;
            end else begin
                if (issue) begin
                    k_reg <= k_reg + 2'd1;
                end
                if (tag_valid) begin
                    acc_reg <= acc_reg + ({32'd0, bus.mul_result} << shift);
                end
            end
            tag_reg[0] <= {issue, k_reg};
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
            if (state_reg == FIX) begin
                result_reg <= fix_value;
            end
        end
    end

    always_comb begin
        bus.mul_ena   = issue;
        bus.mul_dataa = 16'd0;
        bus.mul_datab = 16'd0;
        if (issue) begin
            bus.mul_dataa = k_reg[0] ? a_reg[31:16] : a_reg[15:0];
            bus.mul_datab = k_reg[1] ? b_reg[31:16] : b_reg[15:0];
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.result_lo = result_reg[31:0];
    assign bus.result_hi = result_reg[63:32];
endmodule
